// File: rtl/led_driver3_if.sv
// led_driver3_if: frame request, colour bins and serial LED outputs.
// master drives the bins and start; slave is the driver itself.
interface led_driver3_if #(
  parameter int BIN_QTY = 12,
  parameter int COLOR_W = 24,
  parameter int CNT_W   = 6
);
  logic                              start;
  logic [BIN_QTY-1:0][COLOR_W-1:0]   rgb;
  logic [BIN_QTY-1:0][CNT_W-1:0]     LEDCounts;
  logic                              reverse;
  logic                              dOut;
  logic                              clkOut;
  logic                              done;
  logic                              ready;
  logic                              ovf;

  modport master (
    output start, rgb, LEDCounts, reverse,
    input  dOut, clkOut, done, ready, ovf
  );

  modport slave (
    input  start, rgb, LEDCounts, reverse,
    output dOut, clkOut, done, ready, ovf
  );
endinterface

// File: rtl/led_driver3.sv
// led_driver3: spreads per-bin colours over a serial LED chain.
// One bin is examined per SEEK cycle; words shift out MSB first.
module led_driver3 #(
  parameter int LEDS         = 50,
  parameter int FREQ         = 12_500_000,
  parameter int BIN_QTY      = 12,
  parameter int FREQ_DIV     = 4,
  parameter int COLOR_W      = 24,
  parameter int LATCH_CYCLES = FREQ / 1000
) (
  input logic          clk,
  input logic          rst,
  led_driver3_if.slave bus
);
  localparam int CNT_W = $clog2(LEDS + 1);
  localparam int PTR_W = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam int DIV_W = $clog2(FREQ_DIV);
  localparam int BIT_W = (COLOR_W > 1) ? $clog2(COLOR_W) : 1;
  localparam int GAP_W = $clog2(LATCH_CYCLES + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BIN_QTY - 1);
  localparam logic [CNT_W-1:0] IDX_END  = CNT_W'(LEDS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FREQ_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(COLOR_W - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(LATCH_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    SHIFT
  } state_t;

  typedef logic [BIN_QTY-1:0][COLOR_W-1:0] rgb_t;
  typedef logic [BIN_QTY-1:0][CNT_W-1:0]   cnt_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [COLOR_W-1:0] fill_q, fill_d;
  logic [COLOR_W-1:0] sr_q, sr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               ovf_q, ovf_d;
  logic               rev_q, rev_d;
  rgb_t               rgb_q, rgb_d;
  cnt_t               cnt_q, cnt_d;

  logic             ready;
  logic [PTR_W-1:0] ptr_end;

  assign ready   = (state_q == IDLE) && (gap_q == GAP_MAX);
  assign ptr_end = rev_q ? '0 : PTR_LAST;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    sr_d    = sr_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ovf_d   = ovf_q;
    rev_d   = rev_q;
    rgb_d   = rgb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
        if (ready && bus.start) begin
          rgb_d   = bus.rgb;
          cnt_d   = bus.LEDCounts;
          rev_d   = bus.reverse;
          idx_d   = '0;
          ptr_d   = bus.reverse ? PTR_LAST : '0;
          fill_d  = '0;
          ovf_d   = 1'b0;
          state_d = SEEK;
        end
      end
      SEEK: begin
        div_d = '0;
        bit_d = '0;
        if (cnt_q[ptr_q] != '0) begin
          sr_d         = rgb_q[ptr_q];
          fill_d       = rgb_q[ptr_q];
          cnt_d[ptr_q] = cnt_q[ptr_q] - 1'b1;
          state_d      = SHIFT;
        end else if (ptr_q == ptr_end) begin
          // every bin spent: repeat the last colour loaded
          sr_d    = fill_q;
          state_d = SHIFT;
        end else begin
          ptr_d = rev_q ? ptr_q - 1'b1 : ptr_q + 1'b1;
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            idx_d = idx_q + 1'b1;
            if (idx_d == IDX_END) begin
              state_d = IDLE;
              gap_d   = '0;
              ovf_d   = |cnt_q;
            end else begin
              state_d = SEEK;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            sr_d  = sr_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      fill_q  <= '0;
      sr_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ovf_q   <= 1'b0;
      rev_q   <= 1'b0;
      rgb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ovf_q   <= ovf_d;
      rev_q   <= rev_d;
      rgb_q   <= rgb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.done   = (state_q == IDLE);
  assign bus.ready  = ready;
  assign bus.ovf    = ovf_q;
  assign bus.dOut   = (state_q == SHIFT) & sr_q[COLOR_W-1];
  assign bus.clkOut = (state_q == SHIFT) & div_q[DIV_W-1];
endmodule

// File: tb/tb_led_driver3.sv
// tb_led_driver3: scoreboard bench for the serial LED driver.
// Expected words are queued per frame and matched as they shift out.
module tb_led_driver3;
  localparam int LEDS = 4;
  localparam int BINS = 3;
  localparam int CW   = 24;
  localparam int CNTW = 3;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] BLK = 24'h000000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_driver3_if #(.BIN_QTY(BINS), .COLOR_W(CW), .CNT_W(CNTW)) bus ();

  led_driver3 #(
    .LEDS(LEDS), .FREQ(8000), .BIN_QTY(BINS),
    .FREQ_DIV(4), .COLOR_W(CW), .LATCH_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] word = '0;
  int nbits = 0;
  int rises = 0;
  int ones  = 0;
  logic ck_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.clkOut && !ck_prev) begin
      word = {word[22:0], bus.dOut};
      nbits++;
      rises++;
      if (nbits == CW) begin
        nbits = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected got %h", word);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if (word !== e) begin
            errors++;
            $display("FAIL word got %h want %h", word, e);
          end
        end
      end
    end
    if (bus.dOut === 1'b1) ones++;
    ck_prev = bus.clkOut;
  end

  task automatic set_bins(input logic [2:0] c0, c1, c2,
                          input logic rv);
    bus.rgb       = {BLU, GRN, RED};
    bus.LEDCounts = {c2, c1, c0};
    bus.reverse   = rv;
  endtask

  task automatic send_frame(input logic [2:0] c0, c1, c2,
                            input logic rv,
                            output int len, output int first_hi,
                            output logic ovf_acc);
    bit got;
    int n;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout");
    end
    set_bins(c0, c1, c2, rv);
    bus.start = 1'b1;
    rises = 0;
    ones  = 0;
    nbits = 0;
    @(negedge clk);
    bus.start     = 1'b0;
    ovf_acc       = bus.ovf;
    bus.rgb       = 72'({$urandom(), $urandom(), $urandom()});
    bus.LEDCounts = '1;
    bus.reverse   = ~rv;
    first_hi = 0;
    n = 1;
    while (bus.done !== 1'b1 && n < 3000) begin
      if (bus.clkOut === 1'b1 && first_hi == 0) first_hi = n;
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout");
    end
    len = n - 1;
    set_bins(c0, c1, c2, rv);
  endtask

  task automatic test_reset;
    int k;
    rst = 1'b1;
    bus.start = 1'b1;
    set_bins(3'd1, 3'd1, 3'd1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.dOut !== 1'b0 || bus.clkOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got d%b r%b o%b q%b c%b want 10000",
               bus.done, bus.ready, bus.ovf, bus.dOut, bus.clkOut);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) k = i;
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL reset_ready_delay got %0d want 8", k);
    end
  endtask

  task automatic test_basic;
    int len, fh;
    logic oa;
    exp_q = {RED, GRN, BLU, BLU};
    send_frame(3'd1, 3'd1, 3'd1, 1'b0, len, fh, oa);
    checks++;
    if (len != 390) begin
      errors++;
      $display("FAIL basic_len got %0d want 390", len);
    end
    checks++;
    if (rises != 96) begin
      errors++;
      $display("FAIL basic_rises got %0d want 96", rises);
    end
    checks++;
    if (bus.ovf !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL basic_end got ovf%b done%b want 0 1",
               bus.ovf, bus.done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_words left %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_single_bin;
    int len, fh;
    logic oa;
    exp_q = {GRN, GRN, GRN, GRN};
    send_frame(3'd0, 3'd3, 3'd0, 1'b0, len, fh, oa);
    checks++;
    if (fh != 5) begin
      errors++;
      $display("FAIL single_first_clk got %0d want 5", fh);
    end
    checks++;
    if (len != 390) begin
      errors++;
      $display("FAIL single_len got %0d want 390", len);
    end
    checks++;
    if (exp_q.size() != 0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_end left %0d ovf %b want 0 0",
               exp_q.size(), bus.ovf);
    end
  endtask

  task automatic test_overflow;
    int len, fh;
    logic oa;
    exp_q = {RED, RED, RED, GRN};
    send_frame(3'd3, 3'd3, 3'd0, 1'b0, len, fh, oa);
    checks++;
    if (bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b want 1", bus.ovf);
    end
    checks++;
    if (len != 389 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_frame len %0d left %0d want 389 0",
               len, exp_q.size());
    end
  endtask

  task automatic test_reverse;
    int len, fh;
    logic oa;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold got %b want 1", bus.ovf);
    end
    exp_q = {GRN, GRN, RED, RED};
    send_frame(3'd1, 3'd2, 3'd0, 1'b1, len, fh, oa);
    checks++;
    if (oa !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", oa);
    end
    checks++;
    if (len != 390 || exp_q.size() != 0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reverse_end len %0d left %0d ovf %b want 390 0 0",
               len, exp_q.size(), bus.ovf);
    end
  endtask

  task automatic test_black;
    int len, fh;
    logic oa;
    exp_q = {BLK, BLK, BLK, BLK};
    send_frame(3'd0, 3'd0, 3'd0, 1'b0, len, fh, oa);
    checks++;
    if (ones != 0) begin
      errors++;
      $display("FAIL black_ones got %0d want 0", ones);
    end
    checks++;
    if (rises != 96 || len != 390) begin
      errors++;
      $display("FAIL black_frame rises %0d len %0d want 96 390",
               rises, len);
    end
  endtask

  task automatic test_big_count;
    int len, fh;
    logic oa;
    exp_q = {RED, RED, RED, RED};
    send_frame(3'd7, 3'd0, 3'd0, 1'b0, len, fh, oa);
    checks++;
    if (bus.ovf !== 1'b1 || len != 388 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL big_count ovf %b len %0d left %0d want 1 388 0",
               bus.ovf, len, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int len, fh, k, n;
    logic oa;
    exp_q = {RED, GRN, BLU, BLU};
    send_frame(3'd1, 3'd1, 3'd1, 1'b0, len, fh, oa);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL early_start got done%b ready%b want 1 0",
               bus.done, bus.ready);
    end
    exp_q = {RED, GRN, BLU, BLU};
    rises = 0;
    bus.start = 1'b1;
    k = 0;
    for (int i = 5; i <= 30 && k == 0; i++) begin
      @(negedge clk);
      if (bus.done === 1'b0) k = i;
    end
    bus.start = 1'b0;
    checks++;
    if (k != 9) begin
      errors++;
      $display("FAIL gap_accept got %0d want 9", k);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000 || exp_q.size() != 0 || rises != 96) begin
      errors++;
      $display("FAIL b2b_frame n %0d left %0d rises %0d want <3000 0 96",
               n, exp_q.size(), rises);
    end
  endtask

  task automatic test_rst_mid_shift;
    int n, k;
    repeat (10) @(negedge clk);
    set_bins(3'd1, 3'd1, 3'd1, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.clkOut !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    exp_q.delete();
    nbits = 0;
    checks++;
    if (bus.dOut !== 1'b0 || bus.clkOut !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got q%b c%b d%b want 0 0 1",
               bus.dOut, bus.clkOut, bus.done);
    end
    rst = 1'b0;
    exp_q = {RED, GRN, BLU, BLU};
    k = 0;
    for (int i = 1; i <= 30 && k == 0; i++) begin
      @(negedge clk);
      if (bus.done === 1'b0) k = i;
    end
    bus.start = 1'b0;
    checks++;
    if (k != 9) begin
      errors++;
      $display("FAIL rst_accept got %0d want 9", k);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_frame n %0d left %0d want <3000 0",
               n, exp_q.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    set_bins(3'd0, 3'd0, 3'd0, 1'b0);
    test_reset();
    test_basic();
    test_single_bin();
    test_overflow();
    test_reverse();
    test_black();
    test_big_count();
    test_back_to_back();
    test_rst_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_driver3.md
LED_DRIVER3 -- requirements
Module: led_driver3

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  LEDS, 50, LEDs per frame;
  FREQ, 12_500_000, clk frequency in Hz;
  BIN_QTY, 12, colour bins;
  FREQ_DIV, 4, clk cycles per serial bit, power of 2, at least 2;
  COLOR_W, 24, bits per LED word;
  LATCH_CYCLES, FREQ/1000, minimum idle gap between frames, in clk cycles.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk, in, 1, sole clock;
  rst, in, 1, synchronous active-high reset;
  start, in, 1, frame request;
  rgb, in, [BIN_QTY][COLOR_W], colour per bin;
  LEDCounts, in, [BIN_QTY][$clog2(LEDS+1)], LEDs per bin;
  reverse, in, 1, bin walk order select;
  dOut, out, 1, serial data, MSB first;
  clkOut, out, 1, serial clock;
  done, out, 1, high in IDLE;
  ready, out, 1, start will be accepted this cycle;
  ovf, out, 1, last frame's count sum exceeded LEDS.
REQ-003 All state is clocked on the rising edge of clk; there are no other clocks.

Function
REQ-004 States: IDLE, SEEK, SHIFT.
REQ-005 IDLE: gap counter increments and saturates at LATCH_CYCLES; ready = (IDLE and gap == LATCH_CYCLES).
REQ-006 IDLE to SEEK: start high while ready. In the same edge, rgb, LEDCounts and reverse are snapshotted; LED index = 0; bin pointer = 0 (reverse=0) or BIN_QTY-1 (reverse=1); fill colour = 0; ovf cleared.
REQ-007 start while not ready is ignored and is not queued.
REQ-008 Input changes after acceptance do not affect the current frame.
REQ-009 SEEK examines one bin per cycle.
REQ-010 SEEK, bin remaining count > 0: load its colour into the shift register, decrement that count, set fill colour = that colour, go to SHIFT.
REQ-011 SEEK, bin remaining count == 0: advance the pointer (+1 or -1 per reverse) and stay in SEEK.
REQ-012 SEEK, all bins exhausted: load the fill colour and go to SHIFT. The result is that remaining LEDs repeat the last non-empty bin, or are black (0) if every bin was empty.
REQ-013 SHIFT: each bit lasts exactly FREQ_DIV cycles. dOut holds the bit for the whole period; clkOut = 0 for the first FREQ_DIV/2 cycles and 1 for the last FREQ_DIV/2 cycles.
REQ-014 SHIFT: COLOR_W bits, MSB first.
REQ-015 After the last bit of a word, LED index increments. If the new index == LEDS, go to IDLE with gap = 0; otherwise go to SEEK.
REQ-016 In SEEK and IDLE, clkOut = 0 and dOut = 0.
REQ-017 A frame always emits exactly LEDS words.
REQ-018 If any bin count remains nonzero when LED index reaches LEDS, set ovf = 1; it holds until the next accepted start.
REQ-019 Counts are unsigned. A single bin count > LEDS is legal and is truncated per REQ-017.
REQ-020 done = (state == IDLE).
REQ-021 Frame length = LEDS*COLOR_W*FREQ_DIV + (SEEK cycles) clk cycles, where SEEK cycles >= LEDS.

Reset
REQ-022 rst high on a clock edge: state = IDLE, gap = 0, dOut = 0, clkOut = 0, done = 1, ready = 0, ovf = 0, shift register and snapshots cleared.
REQ-023 Reset takes priority over every event, including start in the same cycle and reset mid-SHIFT.
REQ-024 After reset is released, ready rises exactly LATCH_CYCLES cycles later.

Verification
Bench parameters: LEDS=4, BIN_QTY=3, FREQ_DIV=4, COLOR_W=24, LATCH_CYCLES=8. rgb = {bin0 FF0000, bin1 00FF00, bin2 0000FF}.
REQ-025 counts {1,1,1}, reverse=0 -> words FF0000, 00FF00, 0000FF, 0000FF; 96 clkOut rising edges; ovf=0; done returns.
REQ-026 counts {0,3,0} -> four words 00FF00; the first SHIFT cycle is 2 cycles after acceptance.
REQ-027 counts {3,3,0} -> words FF0000 x3, 00FF00; ovf=1 after the frame.
REQ-028 counts {1,2,0}, reverse=1 -> words 00FF00, 00FF00, FF0000, FF0000.
REQ-029 counts {0,0,0} -> four words 000000; dOut never 1; 96 clkOut edges.
REQ-030 rst pulsed mid-SHIFT, then start held high -> dOut=clkOut=0 the cycle after rst; start accepted exactly 8 cycles after rst is released, not earlier.
